// File: rtl/harp_note_mixer.sv
// Laser-harp square-wave mixer: eight beam-gated phase accumulators summed into one 24-bit sample per tick.
// Optional HARP_DEBOUNCE_EN adds a per-string stability filter on the synchronized beam inputs.

module harp_beam_lane
`ifdef HARP_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 50000)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic beam_async,
  output logic active
);
  logic [1:0] sync;

  always_ff @(posedge clk)
    if (rst) sync <= '0;
    else     sync <= {sync[0], beam_async};

`ifdef HARP_DEBOUNCE_EN
  logic [19:0] cnt;
  logic        act_q;

  // Any cycle where the input agrees with the accepted state restarts the run.
  always_ff @(posedge clk)
    if (rst) begin
      cnt   <= '0;
      act_q <= 1'b0;
    end else if (sync[1] == act_q) begin
      cnt <= '0;
    end else if (cnt == 20'(DEBOUNCE_CYCLES - 1)) begin
      act_q <= sync[1];
      cnt   <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end

  assign active = act_q;
`else
  assign active = sync[1];
`endif
endmodule

module harp_note_mixer #(
  parameter int SAMPLE_DIV      = 1042,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [7:0]  beam_broken,
  input  logic        tune_wr,
  input  logic [2:0]  tune_addr,
  input  logic [23:0] tune_data,
  output logic [23:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [7:0]  active_strings,
  output logic [7:0]  overrun_count
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 24;

  localparam logic signed [26:0] STEP_POS = 27'sd1048576;
  localparam logic signed [26:0] STEP_NEG = -27'sd1048576;
  localparam logic signed [26:0] SAT_HI   = 27'sd8388607;
  localparam logic signed [26:0] SAT_LO   = -27'sd8388608;

  if (SAMPLE_DIV < 12 || SAMPLE_DIV > 65535) begin : g_bad_div
    $error("SAMPLE_DIV out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, LOAD, OUTPUT} state_t;

  typedef struct packed {
    logic             wr;
    logic [2:0]       addr;
    logic [VEC_W-1:0] data;
  } tune_req_t;

  state_t                            state;
  tune_req_t                         tune_req;
  logic [15:0]                       tick_cnt;
  logic                              tick;
  logic [NUM_LANES-1:0][VEC_W-1:0]   phase;
  logic [NUM_LANES-1:0][VEC_W-1:0]   tune;
  logic [NUM_LANES-1:0]              active;
  logic [2:0]                        idx;
  logic signed [26:0]                acc;
  logic signed [26:0]                contrib;
  logic [VEC_W-1:0]                  sat;

  assign tune_req       = '{wr: tune_wr, addr: tune_addr, data: tune_data};
  assign active_strings = active;
  assign tick           = (tick_cnt == 16'(SAMPLE_DIV - 1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    harp_beam_lane
`ifdef HARP_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_lane (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .beam_async (beam_broken[g]),
        .active     (active[g])
      );
  end

  always_ff @(posedge clk_clk)
    if (reset_reset || tick) tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + 16'd1;

  // Registered words: a write lands after the edge, so the string being summed this cycle sees the old word.
  always_ff @(posedge clk_clk)
    if (reset_reset)      tune <= '0;
    else if (tune_req.wr) tune[tune_req.addr] <= tune_req.data;

  always_comb begin
    contrib = phase[idx][VEC_W-1] ? STEP_NEG : STEP_POS;
    if (acc > SAT_HI)      sat = 24'h7FFFFF;
    else if (acc < SAT_LO) sat = 24'h800000;
    else                   sat = acc[VEC_W-1:0];
  end

  always_ff @(posedge clk_clk)
    if (reset_reset) begin
      state         <= IDLE;
      idx           <= '0;
      acc           <= '0;
      phase         <= '0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      overrun_count <= '0;
    end else begin
      // A tick that finds the pipeline busy is lost; phases only move for accepted ticks.
      if (tick && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      case (state)
        IDLE: if (tick) begin
          state <= ACCUM;
          idx   <= '0;
          acc   <= '0;
        end
        ACCUM: begin
          if (active[idx]) begin
            acc        <= acc + contrib;
            phase[idx] <= phase[idx] + tune[idx];
          end else begin
            phase[idx] <= '0;
          end
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= LOAD;
        end
        LOAD: begin
          sample_data  <= sat;
          sample_valid <= 1'b1;
          state        <= OUTPUT;
        end
        OUTPUT: if (sample_ready) begin
          sample_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
